// File: rtl/ssd_tdm_scanner.sv
// ---------------------------------------------------------------------------
// ssd_tdm_scanner
//
// Purpose:
//   This module is the time-division-multiplexed scan controller for a 4-digit
//   common-anode seven-segment display. It steps through the digits round-robin.
//   Each digit slot begins with an anti-ghosting guard period in which all
//   anodes are off. After that comes a show period.
//
//   Display data is double-buffered. A load strobe captures new data into a
//   pending buffer. The pending buffer is promoted to the active buffer only at
//   a frame boundary, which is the wrap from digit 3 back to digit 0. This
//   prevents tearing.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   bcd_in      four BCD digits, [3:0] = digit0 (rightmost), [15:12] = digit3
//   dp_in       decimal point enables, active-high, bit i -> digit i
//   lz_blank    leading-zero blanking enable, captured with load
//   load        single-cycle strobe capturing bcd_in/dp_in/lz_blank as pending
//   display_en  0 blanks the outputs; scanning and buffering keep running
//   load_ack    one-cycle pulse after pending data became active
//   seg_bin     nibble for the seven-segment decoder, 4'hF = blank
//   an          anode select, active-low, one-hot-low or all ones
//   dp          decimal point, active-low
// ---------------------------------------------------------------------------
module ssd_tdm_scanner #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    input  logic        load,
    input  logic        display_en,
    output logic        load_ack,
    output logic [3:0]  seg_bin,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int unsigned     CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   GUARD_END = CW'(GUARD_CYCLES);

    // Phase of the current digit slot, decoded from the scan counter
    typedef enum logic {
        SLOT_GUARD = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_e;

    // Select the nibble belonging to one digit
    function automatic logic [3:0] nibble_sel(input logic [15:0] bcd,
                                              input logic [1:0]  idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = bcd[3:0];
            2'd1:    nib = bcd[7:4];
            2'd2:    nib = bcd[11:8];
            2'd3:    nib = bcd[15:12];
            default: nib = 4'hF;
        endcase
        return nib;
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero.
    // Digit0 always shows.
    function automatic logic lz_blanked(input logic [15:0] bcd,
                                        input logic        lz,
                                        input logic [1:0]  idx);
        logic blank;
        case (idx)
            2'd3:    blank = lz && (bcd[15:12] == 4'h0);
            2'd2:    blank = lz && (bcd[15:8]  == 8'h00);
            2'd1:    blank = lz && (bcd[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

    logic [CW-1:0] cnt_q,        cnt_d;
    logic [1:0]    digit_q,      digit_d;
    logic [15:0]   act_bcd_q,    act_bcd_d;
    logic [3:0]    act_dp_q,     act_dp_d;
    logic          act_lz_q,     act_lz_d;
    logic [15:0]   pend_bcd_q,   pend_bcd_d;
    logic [3:0]    pend_dp_q,    pend_dp_d;
    logic          pend_lz_q,    pend_lz_d;
    logic          pend_valid_q, pend_valid_d;
    logic          load_ack_q,   load_ack_d;
    logic [3:0]    an_q,         an_d;
    logic [3:0]    seg_bin_q,    seg_bin_d;
    logic          dp_q,         dp_d;

    logic          slot_end_s;
    logic          frame_end_s;
    slot_e         phase_s;

    // Next-state logic: scan counter, buffer transfer, and registered outputs
    always_comb begin
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        act_bcd_d    = act_bcd_q;
        act_dp_d     = act_dp_q;
        act_lz_d     = act_lz_q;
        pend_bcd_d   = pend_bcd_q;
        pend_dp_d    = pend_dp_q;
        pend_lz_d    = pend_lz_q;
        pend_valid_d = pend_valid_q;
        load_ack_d   = 1'b0;
        an_d         = 4'b1111;
        seg_bin_d    = 4'hF;
        dp_d         = 1'b1;

        slot_end_s  = (cnt_q == CNT_MAX);
        frame_end_s = slot_end_s && (digit_q == 2'd3);

        if (slot_end_s) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
        end else begin
            cnt_d   = cnt_q + CW'(1);
        end

        // Promote the pending data at the frame boundary. A load issued on the
        // same edge is handled below and becomes pending for the next frame.
        if (frame_end_s && pend_valid_q) begin
            act_bcd_d    = pend_bcd_q;
            act_dp_d     = pend_dp_q;
            act_lz_d     = pend_lz_q;
            pend_valid_d = 1'b0;
            load_ack_d   = 1'b1;
        end else begin
            load_ack_d   = 1'b0;
        end

        if (load) begin
            pend_bcd_d   = bcd_in;
            pend_dp_d    = dp_in;
            pend_lz_d    = lz_blank;
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_d;
        end

        // Outputs are computed from next-cycle state. The registered values
        // therefore match the cnt/digit/active contents of the cycle in which
        // they are visible.
        if (cnt_d < GUARD_END) begin
            phase_s = SLOT_GUARD;
        end else begin
            phase_s = SLOT_SHOW;
        end

        if (display_en && (phase_s == SLOT_SHOW)) begin
            an_d = ~(4'b0001 << digit_d);
            if (!lz_blanked(act_bcd_d, act_lz_d, digit_d)) begin
                seg_bin_d = nibble_sel(act_bcd_d, digit_d);
                dp_d      = ~act_dp_d[digit_d];
            end else begin
                seg_bin_d = 4'hF;
                dp_d      = 1'b1;
            end
        end else begin
            an_d      = 4'b1111;
            seg_bin_d = 4'hF;
            dp_d      = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            act_bcd_q    <= 16'h0000;
            act_dp_q     <= 4'b0000;
            act_lz_q     <= 1'b0;
            pend_bcd_q   <= 16'h0000;
            pend_dp_q    <= 4'b0000;
            pend_lz_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            load_ack_q   <= 1'b0;
            an_q         <= 4'b1111;
            seg_bin_q    <= 4'hF;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            act_bcd_q    <= act_bcd_d;
            act_dp_q     <= act_dp_d;
            act_lz_q     <= act_lz_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            pend_lz_q    <= pend_lz_d;
            pend_valid_q <= pend_valid_d;
            load_ack_q   <= load_ack_d;
            an_q         <= an_d;
            seg_bin_q    <= seg_bin_d;
            dp_q         <= dp_d;
        end
    end

    assign load_ack = load_ack_q;
    assign seg_bin  = seg_bin_q;
    assign an       = an_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_ssd_tdm_scanner.sv
// ---------------------------------------------------------------------------
// tb_ssd_tdm_scanner
//
// This bench drives ssd_tdm_scanner with REFRESH_DIV=8 and GUARD_CYCLES=2.
//
// The reference model tracks the display as a frame position (0..31) plus an
// active and a pending data set. The expected outputs for every clock cycle
// are pushed into a queue, tagged with the clock edge they apply to. A
// separate monitor on the falling edge pops each entry and compares it with
// the DUT outputs.
// ---------------------------------------------------------------------------
module tb_ssd_tdm_scanner;

    localparam int RD    = 8;
    localparam int GC    = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        lz_blank = 1'b0;
    logic        load = 1'b0;
    logic        display_en = 1'b1;
    logic        load_ack;
    logic [3:0]  seg_bin;
    logic [3:0]  an;
    logic        dp;

    always #5 clk = ~clk;

    ssd_tdm_scanner #(
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .load       (load),
        .display_en (display_en),
        .load_ack   (load_ack),
        .seg_bin    (seg_bin),
        .an         (an),
        .dp         (dp)
    );

    typedef struct {
        int unsigned edge_no;
        logic [3:0]  an;
        logic [3:0]  seg;
        logic        dp;
        logic        ack;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_cnt = 0;
    int          n_vec    = 0;
    int          n_fail   = 0;

    // Reference model state
    int          m_pos = 0;
    logic [15:0] m_act_bcd, m_pen_bcd;
    logic [3:0]  m_act_dp,  m_pen_dp;
    logic        m_act_lz,  m_pen_lz, m_pv;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, act, req);
        end
    endtask

    // Monitor: compare the DUT outputs against the entry for this edge
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
            e = exp_q.pop_front();
            if (e.edge_no != edge_cnt) begin
                n_vec++;
                n_fail++;
                $display("FAIL sync: expectation for edge %0d seen at edge %0d", e.edge_no, edge_cnt);
            end
            check("an",       an,              e.an);
            check("seg_bin",  seg_bin,         e.seg);
            check("dp",       {3'b000, dp},       {3'b000, e.dp});
            check("load_ack", {3'b000, load_ack}, {3'b000, e.ack});
        end
    end

    // A digit is blanked when lz is set, it is not digit0, and it and
    // everything to its left are zero.
    function automatic bit is_blank(input logic [15:0] v, input logic lz, input int d);
        if (!lz || d == 0) return 1'b0;
        for (int k = d; k < 4; k++) begin
            if (v[k*4 +: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive one cycle of inputs, predict the outputs after the next edge,
    // then advance one clock.
    task automatic step(input logic r, input logic ld, input logic [15:0] b,
                        input logic [3:0] d, input logic lz, input logic en);
        exp_t e;
        int   np, dg, c;
        rst = r; load = ld; bcd_in = b; dp_in = d; lz_blank = lz; display_en = en;
        e.edge_no = edge_cnt + 1;
        e.an = 4'b1111; e.seg = 4'hF; e.dp = 1'b1; e.ack = 1'b0;
        if (r) begin
            m_pos = 0; m_pv = 1'b0;
            m_act_bcd = 16'h0; m_act_dp = 4'h0; m_act_lz = 1'b0;
            m_pen_bcd = 16'h0; m_pen_dp = 4'h0; m_pen_lz = 1'b0;
        end else begin
            np = (m_pos + 1) % FRAME;
            if (m_pos == FRAME - 1 && m_pv) begin
                m_act_bcd = m_pen_bcd; m_act_dp = m_pen_dp; m_act_lz = m_pen_lz;
                m_pv = 1'b0;
                e.ack = 1'b1;
            end
            if (ld) begin
                m_pen_bcd = b; m_pen_dp = d; m_pen_lz = lz; m_pv = 1'b1;
            end
            dg = np / RD;
            c  = np % RD;
            if (en && c >= GC) begin
                e.an[dg] = 1'b0;
                if (!is_blank(m_act_bcd, m_act_lz, dg)) begin
                    e.seg = m_act_bcd[dg*4 +: 4];
                    e.dp  = ~m_act_dp[dg];
                end
            end
            m_pos = np;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < FRAME && m_pos != p; i++) idle(1);
    endtask

    initial begin
        logic [15:0] rb;
        @(posedge clk);
        #1;
        // 1: reset, then idle scan
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        idle(40);
        // 2: load 1234 with dp on digit1, loaded at cycle 5
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        idle(5);
        step(1'b0, 1'b1, 16'h1234, 4'b0010, 1'b0, 1'b1);
        idle(70);
        // 3: leading-zero blanking
        step(1'b0, 1'b1, 16'h0050, 4'b0000, 1'b1, 1'b1);
        idle(70);
        step(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1, 1'b1);
        idle(70);
        // 4: two loads in one frame, last wins with a single ack
        run_to(3);
        step(1'b0, 1'b1, 16'h1111, 4'b0000, 1'b0, 1'b1);
        idle(4);
        step(1'b0, 1'b1, 16'h2222, 4'b0000, 1'b0, 1'b1);
        idle(70);
        // 5: load on the boundary cycle while older data is pending
        run_to(20);
        step(1'b0, 1'b1, 16'h9999, 4'b0000, 1'b0, 1'b1);
        run_to(FRAME - 1);
        step(1'b0, 1'b1, 16'h7777, 4'b1111, 1'b0, 1'b1);
        idle(100);
        // 6: display disabled for cycles 3..12, reset at cycle 50 with load pending
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        idle(3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        idle(27);
        step(1'b0, 1'b1, 16'h8888, 4'b1111, 1'b0, 1'b1);
        idle(9);
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        idle(70);
        // 7: random traffic
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < 4; k++) begin
                rb[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 19) == 0),
                 rb,
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) != 0));
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
